// File: rtl/div_pkg.sv
// Shared constants and state encoding for the 8/4 signed sequential divider.
package div_pkg;
   localparam int DW    = 8;
   localparam int VW    = 4;
   localparam int NITER = 8;
   localparam int CW    = 3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_e;
endpackage

// File: rtl/seq_div8x4_if.sv
// Request/result bundle between a requester and the divider.
interface seq_div8x4_if;
   import div_pkg::*;

   logic          start;
   logic [DW-1:0] Dividend;
   logic [VW-1:0] Divisor;
   logic          busy;
   logic          done;
   logic [DW-1:0] Quotient;
   logic [VW-1:0] Remainder;
   logic          DivZero;
   logic          Ovf;

   modport master (
      output start, Dividend, Divisor,
      input  busy, done, Quotient, Remainder, DivZero, Ovf
   );

   modport slave (
      input  start, Dividend, Divisor,
      output busy, done, Quotient, Remainder, DivZero, Ovf
   );
endinterface

// File: rtl/div_step5.sv
// One restoring-division step: compare shifted partial remainder
// against the divisor magnitude and subtract when it fits.
module div_step5
   import div_pkg::*;
(
   input  logic [VW:0]   p_i,
   input  logic [VW-1:0] d_i,
   output logic [VW:0]   p_o,
   output logic          q_o
);
   logic [VW:0] d_ext;

   assign d_ext = {1'b0, d_i};
   assign q_o   = (p_i >= d_ext);
   assign p_o   = q_o ? (p_i - d_ext) : p_i;
endmodule

// File: rtl/seq_div8x4.sv
// Signed 8-by-4 restoring divider: magnitude capture, 8 shift/subtract
// iterations, then sign fix-up; quotient truncates toward zero.
module seq_div8x4 #(
   parameter int DW = 8,
   parameter int VW = 4
) (
   input  logic         clk,
   input  logic         rst,
   seq_div8x4_if.slave  bus
);
   import div_pkg::*;

   state_e        state_q, state_d;
   logic [DW-1:0] a_q, a_d;
   logic [VW-1:0] d_q, d_d;
   logic [VW:0]   p_q, p_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sdd_q, sdd_d;
   logic          sdv_q, sdv_d;
   logic          ovfp_q, ovfp_d;
   logic [DW-1:0] quo_q, quo_d;
   logic [VW-1:0] rem_q, rem_d;
   logic          dz_q, dz_d;
   logic          ovf_q, ovf_d;
   logic          done_q, done_d;

   logic [VW:0]   p_shift;
   logic [VW:0]   p_nxt;
   logic          q_bit;

   function automatic logic [DW-1:0] neg_a(input logic [DW-1:0] x);
      return ~x + DW'(1);
   endfunction

   function automatic logic [VW-1:0] neg_v(input logic [VW-1:0] x);
      return ~x + VW'(1);
   endfunction

   assign p_shift = {p_q[VW-1:0], a_q[DW-1]};

   div_step5 u_step (
      .p_i (p_shift),
      .d_i (d_q),
      .p_o (p_nxt),
      .q_o (q_bit)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      d_d     = d_q;
      p_d     = p_q;
      cnt_d   = cnt_q;
      sdd_d   = sdd_q;
      sdv_d   = sdv_q;
      ovfp_d  = ovfp_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dz_d    = dz_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               sdd_d  = bus.Dividend[DW-1];
               sdv_d  = bus.Divisor[VW-1];
               a_d    = bus.Dividend[DW-1] ? neg_a(bus.Dividend) : bus.Dividend;
               d_d    = bus.Divisor[VW-1] ? neg_v(bus.Divisor) : bus.Divisor;
               p_d    = '0;
               cnt_d  = '0;
               ovfp_d = (bus.Dividend == {1'b1, {(DW-1){1'b0}}}) &&
                        (bus.Divisor == '1);
               // Zero divisor skips the iterations and reports at once
               if (bus.Divisor == '0) begin
                  quo_d   = '0;
                  rem_d   = '0;
                  dz_d    = 1'b1;
                  ovf_d   = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            p_d   = p_nxt;
            a_d   = {a_q[DW-2:0], q_bit};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(NITER - 1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            quo_d   = (sdd_q ^ sdv_q) ? neg_a(a_q) : a_q;
            rem_d   = sdd_q ? neg_v(p_q[VW-1:0]) : p_q[VW-1:0];
            dz_d    = 1'b0;
            ovf_d   = ovfp_q;
            done_d  = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         d_q     <= '0;
         p_q     <= '0;
         cnt_q   <= '0;
         sdd_q   <= 1'b0;
         sdv_q   <= 1'b0;
         ovfp_q  <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         d_q     <= d_d;
         p_q     <= p_d;
         cnt_q   <= cnt_d;
         sdd_q   <= sdd_d;
         sdv_q   <= sdv_d;
         ovfp_q  <= ovfp_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy      = (state_q == S_CALC) || (state_q == S_FIX);
   assign bus.done      = done_q;
   assign bus.Quotient  = quo_q;
   assign bus.Remainder = rem_q;
   assign bus.DivZero   = dz_q;
   assign bus.Ovf       = ovf_q;
endmodule
